updown_modn_counter: RTL and testbench

Parametrised up/down modulo-N counter; successor to the fixed mod-5 up/down counter.
- Adds count enable, synchronous clear, parallel load with range check, and selectable wrap or saturate mode.
- Adds registered overflow/underflow pulses and terminal-count flags.
- Used as a generic position/index counter inside control FSMs and timers.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/updown_modn_counter.sv | 99 +++++++++
 tb/tb_updown_modn_counter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo-N counter family.
package counter_pkg;

  // Direction encoding for the inc input.
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Ceiling log2, used to confirm the counter width can hold MODULUS-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/updown_modn_counter.sv
// Parametrised up/down modulo-N counter with clear, range-checked load,
// wrap or saturate at the bounds, and registered ovf/unf/load_err pulses.
module updown_modn_counter
  import counter_pkg::*;
#(
  parameter int MODULUS  = 5,
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             unf,
  output logic             load_err,
  output logic             at_max,
  output logic             at_zero
);

  // Reject parameter sets whose count range does not fit the register.
  if (MODULUS < 2 || MODULUS > 256) begin : g_bad_modulus
    $error("updown_modn_counter: MODULUS %0d outside 2..256", MODULUS);
  end
  if (clog2(MODULUS) > WIDTH) begin : g_bad_width
    $error("updown_modn_counter: WIDTH %0d too small for MODULUS %0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             load_err_nxt;

  // Next-state selection with priority clr > load > en > hold.
  always_comb begin
    cnt_nxt      = cnt;
    ovf_nxt      = 1'b0;
    unf_nxt      = 1'b0;
    load_err_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      if (load_val > MAX_VAL) begin
        load_err_nxt = 1'b1;
      end else begin
        cnt_nxt = load_val;
      end
    end else if (en) begin
      // An out-of-range value (only reachable via X or force) goes to 0
      // on the next step rather than propagating garbage.
      if (!(cnt <= MAX_VAL)) begin
        cnt_nxt = '0;
      end else if (inc == CNT_UP) begin
        if (cnt == MAX_VAL) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SATURATE ? MAX_VAL : '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else begin
        if (cnt == '0) begin
          unf_nxt = 1'b1;
          cnt_nxt = SATURATE ? '0 : MAX_VAL;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
    end
  end

  // State and pulse registers; pulses are rewritten every cycle so they never stick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ovf      <= ovf_nxt;
      unf      <= unf_nxt;
      load_err <= load_err_nxt;
    end
  end

  // Terminal-count flags decode straight from the register.
  always_comb begin
    at_max  = (cnt == MAX_VAL);
    at_zero = (cnt == '0);
  end

endmodule

// File: tb/tb_updown_modn_counter.sv
// Bench for updown_modn_counter: a wrapping mod-5 instance and a saturating
// mod-10 instance share control stimulus; a reference model pushes expected
// results into per-instance queues that are popped after each clock edge.
`timescale 1ns/1ps
module tb_updown_modn_counter;

  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit lerr;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       load;
  logic       en;
  logic       inc;
  logic [2:0] lv5;
  logic [3:0] lv10;

  logic [2:0] cnt5;
  logic       ovf5, unf5, lerr5, max5, zero5;
  logic [3:0] cnt10;
  logic       ovf10, unf10, lerr10, max10, zero10;

  int n_vec;
  int n_err;
  int m5;
  int m10;
  exp_t q5[$];
  exp_t q10[$];

  updown_modn_counter #(.MODULUS(5), .WIDTH(3), .SATURATE(1'b0)) dut5 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(lv5),
    .en(en), .inc(inc), .cnt(cnt5), .ovf(ovf5), .unf(unf5),
    .load_err(lerr5), .at_max(max5), .at_zero(zero5)
  );

  updown_modn_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(1'b1)) dut10 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(lv10),
    .en(en), .inc(inc), .cnt(cnt10), .ovf(ovf10), .unf(unf10),
    .load_err(lerr10), .at_max(max10), .at_zero(zero10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic exp_t model(input int cur, input int modulus, input bit sat,
                                 input bit c, input bit l, input int lv,
                                 input bit e, input bit up);
    exp_t r;
    r.cnt = cur; r.ovf = 0; r.unf = 0; r.lerr = 0;
    if (c) r.cnt = 0;
    else if (l) begin
      if (lv >= modulus) r.lerr = 1;
      else r.cnt = lv;
    end else if (e) begin
      if (up) begin
        if (cur == modulus - 1) begin
          r.ovf = 1;
          r.cnt = sat ? cur : 0;
        end else r.cnt = cur + 1;
      end else begin
        if (cur == 0) begin
          r.unf = 1;
          r.cnt = sat ? 0 : modulus - 1;
        end else r.cnt = cur - 1;
      end
    end
    return r;
  endfunction

  task automatic check5(input exp_t x);
    chk("cnt5", int'(cnt5), x.cnt);
    chk("ovf5", int'(ovf5), int'(x.ovf));
    chk("unf5", int'(unf5), int'(x.unf));
    chk("lerr5", int'(lerr5), int'(x.lerr));
    chk("max5", int'(max5), int'(x.cnt == 4));
    chk("zero5", int'(zero5), int'(x.cnt == 0));
  endtask

  task automatic check10(input exp_t x);
    chk("cnt10", int'(cnt10), x.cnt);
    chk("ovf10", int'(ovf10), int'(x.ovf));
    chk("unf10", int'(unf10), int'(x.unf));
    chk("lerr10", int'(lerr10), int'(x.lerr));
    chk("max10", int'(max10), int'(x.cnt == 9));
    chk("zero10", int'(zero10), int'(x.cnt == 0));
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e5;
    exp_t e10;
    e5  = model(m5, 5, 1'b0, clr, load, int'(lv5), en, inc);
    e10 = model(m10, 10, 1'b1, clr, load, int'(lv10), en, inc);
    q5.push_back(e5);
    q10.push_back(e10);
    m5  = e5.cnt;
    m10 = e10.cnt;
    @(posedge clk);
    #1;
    if (q5.size() == 0) chk("q5_empty", 1, 0);
    else check5(q5.pop_front());
    if (q10.size() == 0) chk("q10_empty", 1, 0);
    else check10(q10.pop_front());
  endtask

  task automatic drive(input bit c, input bit l, input int v5, input int v10,
                       input bit e, input bit up, input int n);
    clr = c; load = l; lv5 = 3'(v5); lv10 = 4'(v10); en = e; inc = up;
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset between edges must clear immediately; hold it over one edge.
  task automatic async_reset();
    exp_t z;
    z.cnt = 0; z.ovf = 0; z.unf = 0; z.lerr = 0;
    #3;
    reset_n = 1'b0;
    #1;
    check5(z);
    check10(z);
    @(posedge clk);
    #1;
    check5(z);
    check10(z);
    reset_n = 1'b1;
    m5 = 0;
    m10 = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; m5 = 0; m10 = 0;
    reset_n = 1'b0;
    clr = 0; load = 0; en = 0; inc = 0; lv5 = '0; lv10 = '0;
    @(posedge clk);
    #1;
    async_reset();

    // Count a little, then reset mid-run, then the 6-step up sequence.
    drive(0, 0, 0, 0, 1, 1, 3);
    async_reset();
    drive(0, 0, 0, 0, 1, 1, 6);

    // Down wrap from 0 (mod-5) and down-block at 0 (saturating).
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 3);

    // Saturation: 12 up steps from 0, then down from 0.
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 12);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 2);

    // Load in range, then out of range (count holds, one-cycle error).
    drive(0, 1, 3, 3, 0, 0, 1);
    drive(0, 1, 6, 12, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 7, 10, 1, 1, 1);
    drive(0, 1, 4, 9, 0, 0, 1);

    // Priority: clr beats load and en; load beats en.
    drive(1, 1, 2, 2, 1, 1, 1);
    drive(0, 1, 2, 2, 1, 1, 1);

    // Enable low holds the count.
    drive(0, 0, 0, 0, 0, 1, 5);

    // Down count through zero repeatedly (consecutive pulses in saturate).
    drive(0, 0, 0, 0, 1, 0, 4);

    // Randomised mix.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 1);
    end

    async_reset();
    drive(0, 0, 0, 0, 1, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
